// File: rtl/parity_frame_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_checker_if
// Purpose  : Serial-bit input stream, parity mode and status/result bundle
//            between a parity-framed serial link and parity_frame_checker.
// Revision : 1.0 - initial release
// ============================================================================
interface parity_frame_checker_if #(
    parameter int DATA_W = 7,
    parameter int CNT_W  = 8
);
    // Serial side
    logic              control;
    logic              in_valid;
    logic              in_sof;
    logic              in_bit;
    logic              clear_count;

    // Result side
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              parity_error;
    logic              frame_error;
    logic              busy;
    logic [CNT_W-1:0]  error_count;

    // Producer of serial bits / consumer of recovered words
    modport master (
        output control, in_valid, in_sof, in_bit, clear_count,
        input  data_out, out_valid, parity_error, frame_error, busy, error_count
    );

    // The checker itself
    modport slave (
        input  control, in_valid, in_sof, in_bit, clear_count,
        output data_out, out_valid, parity_error, frame_error, busy, error_count
    );
endinterface
`default_nettype wire

// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_checker
// Purpose  : Deserializes LSB-first frames of DATA_W data bits plus a parity
//            bit, checks parity against the even/odd mode latched on the
//            start-of-frame bit, reports the word with status pulses and keeps
//            a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module parity_frame_checker #(
    parameter int DATA_W = 7,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    parity_frame_checker_if.slave bus
);

    // Index must reach DATA_W, the parity-bit position
    localparam int              c_idx_w   = $clog2(DATA_W + 1);
    localparam logic [c_idx_w-1:0] c_par_idx = c_idx_w'(DATA_W);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_recv = 1'b1;

    logic [0:0]         r_state;
    logic [c_idx_w-1:0] r_idx;
    logic [DATA_W-1:0]  r_shift;
    logic               r_mode;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_out_valid;
    logic               r_parity_error;
    logic               r_frame_error;
    logic               r_busy;
    logic [CNT_W-1:0]   r_error_count;

    logic               w_in_recv;
    logic               w_restart;
    logic               w_last_bit;
    logic               w_parity_fail;
    logic               w_count_inc;
    logic [DATA_W-1:0]  w_shift_next;

    assign w_in_recv     = (r_state == c_st_recv);
    // A start-of-frame bit while receiving aborts the partial frame
    assign w_restart     = w_in_recv & bus.in_valid & bus.in_sof;
    assign w_last_bit    = w_in_recv & bus.in_valid & ~bus.in_sof & (r_idx == c_par_idx);
    // XOR over data and parity is 0 for an even count of ones; odd mode inverts
    assign w_parity_fail = (^r_shift) ^ bus.in_bit ^ r_mode;
    assign w_count_inc   = w_restart | (w_last_bit & w_parity_fail);

    // Shift register with the incoming bit written at the current index
    always_comb begin
        w_shift_next = r_shift;
        for (int i = 0; i < DATA_W; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_shift_next[i] = bus.in_bit;
            end
        end
    end

    // Frame reception state machine with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_idx          <= '0;
            r_shift        <= '0;
            r_mode         <= 1'b0;
            r_data_out     <= '0;
            r_out_valid    <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_out_valid   <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // Bits without a start marker are silently dropped
                    if (bus.in_valid && bus.in_sof) begin
                        r_shift <= DATA_W'(bus.in_bit);
                        r_mode  <= bus.control;
                        r_idx   <= c_idx_w'(1);
                        r_state <= c_st_recv;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_recv: begin
                    if (bus.in_valid) begin
                        if (bus.in_sof) begin
                            // Discard partial frame; this bit opens the next one
                            r_frame_error <= 1'b1;
                            r_shift       <= DATA_W'(bus.in_bit);
                            r_mode        <= bus.control;
                            r_idx         <= c_idx_w'(1);
                        end else if (r_idx == c_par_idx) begin
                            r_data_out     <= r_shift;
                            r_parity_error <= w_parity_fail;
                            r_out_valid    <= 1'b1;
                            r_idx          <= '0;
                            r_state        <= c_st_idle;
                            r_busy         <= 1'b0;
                        end else begin
                            r_shift <= w_shift_next;
                            r_idx   <= r_idx + c_idx_w'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating error counter; a clear wins over a coincident increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error_count <= '0;
        end else if (bus.clear_count) begin
            r_error_count <= '0;
        end else if (w_count_inc && (r_error_count != c_cnt_max)) begin
            r_error_count <= r_error_count + CNT_W'(1);
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.out_valid    = r_out_valid;
    assign bus.parity_error = r_parity_error;
    assign bus.frame_error  = r_frame_error;
    assign bus.busy         = r_busy;
    assign bus.error_count  = r_error_count;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_checker
// Purpose  : Randomized scoreboard bench for parity_frame_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_frame_checker;

    localparam int DATA_W = 7;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    typedef struct {
        bit                is_abort;
        logic [DATA_W-1:0] data;
        logic              perr;
        logic [CNT_W-1:0]  count;
        int                cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t sb[$];

    // Reference model state
    int                m_count = 0;
    logic [DATA_W-1:0] m_last  = '0;
    bit                m_busy  = 1'b0;

    parity_frame_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    parity_frame_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int sat_inc(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    // Monitor: every result or abort pulse must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1 || bus.frame_error === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got out_valid=%0b frame_error=%0b expected none (cycle %0d)",
                         bus.out_valid, bus.frame_error, cyc);
            end else begin
                e = sb.pop_front();
                chk("frame_error", 32'(bus.frame_error), 32'(e.is_abort));
                chk("out_valid", 32'(bus.out_valid), 32'(!e.is_abort));
                chk("event_cycle", 32'(cyc), 32'(e.cyc));
                chk("data_out", 32'(bus.data_out), 32'(e.data));
                if (!e.is_abort) chk("parity_error", 32'(bus.parity_error), 32'(e.perr));
                chk("error_count", 32'(bus.error_count), 32'(e.count));
            end
        end
    end

    task automatic drive(input logic v, input logic sof, input logic b, input logic ctrl, input logic clr);
        bus.in_valid    = v;
        bus.in_sof      = sof;
        bus.in_bit      = b;
        bus.control     = ctrl;
        bus.clear_count = clr;
        @(posedge clk);
        #1;
    endtask

    // maxn < 0 means exactly one idle cycle; otherwise 0..maxn random ones
    task automatic stall(input int maxn);
        int n;
        n = (maxn < 0) ? 1 : int'($urandom_range(0, maxn));
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic push_abort_if_busy();
        exp_t e;
        if (m_busy) begin
            m_count = sat_inc(m_count);
            e = '{1'b1, m_last, 1'b0, CNT_W'(m_count), cyc + 1};
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic mode,
                              input int stall_max, input logic clr);
        exp_t e;
        logic perr;
        logic b;
        for (int i = 0; i <= DATA_W; i++) begin
            stall(stall_max);
            if (i == 0) push_abort_if_busy();
            if (i == DATA_W) begin
                perr = (^d) ^ p ^ mode;
                if (clr) m_count = 0;
                else if (perr) m_count = sat_inc(m_count);
                m_last = d;
                e = '{1'b0, d, perr, CNT_W'(m_count), cyc + 1};
                sb.push_back(e);
            end
            b = (i < DATA_W) ? d[i] : p;
            drive(1'b1, (i == 0), b, (i == 0) ? mode : 1'($urandom_range(0, 1)),
                  (i == DATA_W) ? clr : 1'b0);
            if (i == 0) chk("busy_after_sof", 32'(bus.busy), 32'd1);
        end
        m_busy = 1'b0;
        chk("busy_after_frame", 32'(bus.busy), 32'd0);
    endtask

    task automatic send_partial(input logic [DATA_W-1:0] d, input int n, input logic mode);
        for (int i = 0; i < n; i++) begin
            if (i == 0) push_abort_if_busy();
            drive(1'b1, (i == 0), d[i], (i == 0) ? mode : 1'($urandom_range(0, 1)), 1'b0);
        end
        m_busy = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no completion expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        chk("reset_data_out", 32'(bus.data_out), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_parity_error", 32'(bus.parity_error), 32'd0);
        chk("reset_frame_error", 32'(bus.frame_error), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_error_count", 32'(bus.error_count), 32'd0);

        // Basic even and odd frames
        send_frame(7'b1010101, 1'b0, 1'b0, 0, 1'b0);
        send_frame(7'b0000111, 1'b1, 1'b1, 0, 1'b0);
        send_frame(7'b0000111, 1'b0, 1'b1, 0, 1'b0);

        // Alternating valid/stall
        t0 = cyc;
        send_frame(7'h5A, 1'b0, 1'b0, -1, 1'b0);
        chk("toggle_cycles", 32'(cyc - t0), 32'd16);

        // Premature start-of-frame, then a clean frame
        send_partial(7'h11, 4, 1'b0);
        send_frame(7'h22, 1'b0, 1'b0, 0, 1'b0);

        // Full sweep with random stalls, mid-frame control noise and aborts
        for (int d = 0; d < 128; d++)
            for (int m = 0; m < 2; m++)
                for (int p = 0; p < 2; p++) begin
                    if ($urandom_range(0, 15) == 0)
                        send_partial(DATA_W'($urandom), int'($urandom_range(1, DATA_W)),
                                     1'($urandom_range(0, 1)));
                    send_frame(DATA_W'(d), 1'(p), 1'(m), 2, 1'b0);
                end

        // Saturation: clear, then 256 failing frames, then clear with a failure
        send_frame(7'h00, 1'b0, 1'b0, 0, 1'b1);
        for (int k = 0; k < 256; k++) send_frame(7'h00, 1'b1, 1'b0, 0, 1'b0);
        chk("count_saturated", 32'(bus.error_count), 32'(CMAX));
        send_frame(7'h00, 1'b1, 1'b0, 0, 1'b0);
        chk("count_holds", 32'(bus.error_count), 32'(CMAX));
        send_frame(7'h00, 1'b1, 1'b0, 0, 1'b1);
        chk("count_cleared", 32'(bus.error_count), 32'd0);

        // Reset during a frame
        send_frame(7'h01, 1'b0, 1'b0, 0, 1'b0);
        send_partial(7'h55, 3, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        m_count = 0;
        m_last  = '0;
        m_busy  = 1'b0;
        chk("rst_mid_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_parity_error", 32'(bus.parity_error), 32'd0);
        chk("rst_mid_error_count", 32'(bus.error_count), 32'd0);
        for (int k = 0; k < 2 * (DATA_W + 1); k++)
            drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        chk("stray_bits_busy", 32'(bus.busy), 32'd0);
        send_frame(7'h3C, 1'b1, 1'b1, 1, 1'b0);

        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
